// File: rtl/pipe_pkg.sv
// Shared pipeline constants: instruction codes, status codes, the "no register" ID
// and the default field widths used by the stage registers.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned REG_W_DEF   = 4;
    localparam int unsigned ICODE_W_DEF = 4;
    localparam int unsigned STAT_W_DEF  = 3;

    localparam logic [ICODE_W_DEF-1:0] IHALT = 4'd0;
    localparam logic [ICODE_W_DEF-1:0] INOP  = 4'd1;

    localparam logic [REG_W_DEF-1:0] RNONE = 4'hF;

    localparam logic [STAT_W_DEF-1:0] SAOK = 3'd1;
    localparam logic [STAT_W_DEF-1:0] SHLT = 3'd2;
    localparam logic [STAT_W_DEF-1:0] SADR = 3'd3;
    localparam logic [STAT_W_DEF-1:0] SINS = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_wb_reg.sv
// M->W pipeline register with stall, bubble and a sticky halt that freezes the stage.
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module pipe_wb_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned ICODE_W = ICODE_W_DEF,
    parameter int unsigned STAT_W  = STAT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               W_stall,
    input  logic               W_bubble,
    input  logic [ICODE_W-1:0] m_icode,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [DATA_W-1:0]  m_valE,
    input  logic [DATA_W-1:0]  m_valM,
    input  logic [REG_W-1:0]   m_dstE,
    input  logic [REG_W-1:0]   m_dstM,
    output logic [ICODE_W-1:0] W_icode,
    output logic [STAT_W-1:0]  W_stat,
    output logic [DATA_W-1:0]  W_valE,
    output logic [DATA_W-1:0]  W_valM,
    output logic [REG_W-1:0]   W_dstE,
    output logic [REG_W-1:0]   W_dstM,
    output logic               W_we_e,
    output logic               W_we_m,
    output logic               W_halted
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    localparam logic [ICODE_W-1:0] NopIcode = ICODE_W'(INOP);
    localparam logic [STAT_W-1:0]  OkStat   = STAT_W'(SAOK);
    localparam logic [REG_W-1:0]   NoReg    = REG_W'(RNONE);

    logic [ICODE_W-1:0] icode_q, icode_d;
    logic [STAT_W-1:0]  stat_q,  stat_d;
    logic [DATA_W-1:0]  vale_q,  vale_d;
    logic [DATA_W-1:0]  valm_q,  valm_d;
    logic [REG_W-1:0]   dste_q,  dste_d;
    logic [REG_W-1:0]   dstm_q,  dstm_d;
    logic               halted_q, halted_d;

    logic stall_take;
    logic bubble_take;
    logic load_take;

    // Halt outranks stall, stall outranks bubble.
    assign stall_take  = !halted_q && W_stall;
    assign bubble_take = !halted_q && !W_stall && W_bubble;
    assign load_take   = !halted_q && !W_stall && !W_bubble;

    always_comb begin
        icode_d  = icode_q;
        stat_d   = stat_q;
        vale_d   = vale_q;
        valm_d   = valm_q;
        dste_d   = dste_q;
        dstm_d   = dstm_q;
        halted_d = halted_q;
        if (bubble_take) begin
            icode_d = NopIcode;
            stat_d  = OkStat;
            vale_d  = '0;
            valm_d  = '0;
            dste_d  = NoReg;
            dstm_d  = NoReg;
        end else if (load_take) begin
            icode_d  = m_icode;
            stat_d   = m_stat;
            vale_d   = m_valE;
            valm_d   = m_valM;
            dste_d   = m_dstE;
            dstm_d   = m_dstM;
            halted_d = (m_stat != OkStat);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icode_q  <= NopIcode;
            stat_q   <= OkStat;
            vale_q   <= '0;
            valm_q   <= '0;
            dste_q   <= NoReg;
            dstm_q   <= NoReg;
            halted_q <= 1'b0;
        end else begin
            icode_q  <= icode_d;
            stat_q   <= stat_d;
            vale_q   <= vale_d;
            valm_q   <= valm_d;
            dste_q   <= dste_d;
            dstm_q   <= dstm_d;
            halted_q <= halted_d;
        end
    end

    assign W_icode  = icode_q;
    assign W_stat   = stat_q;
    assign W_valE   = vale_q;
    assign W_valM   = valm_q;
    assign W_dstE   = dste_q;
    assign W_dstM   = dstm_q;
    assign W_halted = halted_q;

    // A non-OK status suppresses both writes, so a halting instruction never commits.
    assign W_we_e = (dste_q != NoReg) && (stat_q == OkStat);
    assign W_we_m = (dstm_q != NoReg) && (stat_q == OkStat);

`ifdef WB_PERF_CNT_EN
    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_take),
        .count (perf_stall_cnt)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_take),
        .count (perf_bubble_cnt)
    );
`endif

endmodule
